// File: rtl/console_drain_arbiter.sv
// Round-robin drain of N_CH console byte FIFOs into one valid/ready TX stream.
// A tag byte (TAG_BASE | ch) precedes data whenever the source channel changes.
module console_drain_arbiter #(
  parameter int              N_CH     = 4,
  parameter int              WIDTH    = 8,
  parameter int              BURST    = 16,
  parameter logic [WIDTH-1:0] TAG_BASE = 'hF0,
  localparam int             CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       fifo_empty,
  input  logic [N_CH*WIDTH-1:0] fifo_data,
  output logic [N_CH-1:0]       fifo_advance,
  output logic [WIDTH-1:0]      tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [CW-1:0]         grant_ch,
  output logic                  busy
);

  localparam int CNTW = $clog2(BURST + 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, TAG, LOAD, SEND, WAIT1, WAIT2
  } state_t;

  state_t                        state_q, state_d;
  logic                          tx_valid_q, tx_valid_d;
  logic [WIDTH-1:0]              tx_data_q, tx_data_d;
  logic [N_CH-1:0]               adv_q, adv_d;
  logic [CW-1:0]                 grant_q, grant_d;
  logic [CW-1:0]                 rr_q, rr_d;
  logic [CNTW-1:0]               cnt_q, cnt_d;
  logic                          busy_q, busy_d;
  logic                          ltv_q, ltv_d;
  logic [CW-1:0]                 ltc_q, ltc_d;

  logic [N_CH-1:0][WIDTH-1:0]    ch_data;
  logic                          found;
  logic [CW-1:0]                 pick;
  logic [CW-1:0]                 cand;
  int                            idx;
  logic                          hs;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign ch_data[g] = fifo_data[g*WIDTH +: WIDTH];
  end

  // First non-empty FIFO at or after rr_q, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = CW'(idx);
      if (!found && !fifo_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign hs = tx_valid_q && tx_ready;

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    adv_d      = '0;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    ltv_d      = ltv_q;
    ltc_d      = ltc_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: if (!ltv_q || ltc_q != grant_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = TAG_BASE | WIDTH'(grant_q);
        state_d    = TAG;
      end else begin
        state_d = LOAD;
      end
      TAG: if (hs) begin
        tx_valid_d = 1'b0;
        ltv_d      = 1'b1;
        ltc_d      = grant_q;
        state_d    = LOAD;
      end
      LOAD: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ch_data[grant_q];
        state_d    = SEND;
      end
      SEND: if (hs) begin
        tx_valid_d     = 1'b0;
        adv_d[grant_q] = 1'b1;
        cnt_d          = cnt_q + CNTW'(1);
        state_d        = WAIT1;
      end
      WAIT1: state_d = WAIT2;
      // fifo_empty reflects the advance by now; fifo_data catches up during LOAD.
      WAIT2: if (!fifo_empty[grant_q] && cnt_q < CNTW'(BURST)) begin
        state_d = LOAD;
      end else begin
        rr_d    = (grant_q == CW'(N_CH - 1)) ? '0 : grant_q + CW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      adv_q      <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ltv_q      <= 1'b0;
      ltc_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      adv_q      <= adv_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      ltv_q      <= ltv_d;
      ltc_q      <= ltc_d;
    end
  end

  assign fifo_advance = adv_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign grant_ch     = grant_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_console_drain_arbiter.sv
// Directed bench for console_drain_arbiter: FIFO models with the registered
// empty/data timing, a TX stream recorder, and protocol watchers.
module tb_console_drain_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  fifo_advance;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [1:0]  grant_ch;
  logic        busy;

  console_drain_arbiter dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_advance(fifo_advance), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant_ch(grant_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: empty updates 1 cycle after push/advance, data 1 cycle later.
  logic [7:0]      mem [4][256];
  int              wp [4] = '{default: 0};
  int              rp [4] = '{default: 0};
  logic [3:0]      emp = 4'hF;
  logic [3:0][7:0] hd1 = '0;
  logic [3:0][7:0] fdat = '0;
  int              prot_err = 0;
  int              adv_cnt [4] = '{default: 0};

  assign fifo_empty = emp;
  assign fifo_data  = fdat;

  always @(posedge clk) begin
    if ($countones(fifo_advance) > 1) begin
      prot_err++;
      $display("FAIL advance_onehot: got %b required at most one bit", fifo_advance);
    end
    for (int k = 0; k < 4; k++) begin
      if (fifo_advance[k]) begin
        adv_cnt[k]++;
        if (rp[k] == wp[k]) begin
          prot_err++;
          $display("FAIL advance_empty: ch %0d advanced while empty", k);
        end else rp[k]++;
      end
      emp[k]  <= (rp[k] == wp[k]);
      hd1[k]  <= (rp[k] != wp[k]) ? mem[k][rp[k]] : 8'h00;
      fdat[k] <= hd1[k];
    end
  end

  // TX recorder and hold-stability watcher.
  logic [7:0] rx [256];
  int         rx_n = 0;
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pd = '0;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      rx[rx_n] = tx_data;
      rx_n++;
    end
    if (pv && !pr && !prst && (!tx_valid || tx_data != pd)) begin
      prot_err++;
      $display("FAIL tx_hold: got v=%0b d=%h required v=1 d=%h", tx_valid, tx_data, pd);
    end
    pv = tx_valid; pr = tx_ready; pd = tx_data; prst = rst;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] v);
    mem[k][wp[k]] = v;
    wp[k]++;
  endtask

  logic [7:0] ex [32];
  int         ex_n;
  int         rx_base;

  task automatic wait_rx(input int n, input string nm);
    int t = 0;
    while (rx_n - rx_base < n && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_timeout"}, int'(rx_n - rx_base >= n), 1);
  endtask

  task automatic check_stream(input string nm);
    wait_rx(ex_n, nm);
    repeat (12) @(negedge clk);
    chk({nm, "_len"}, rx_n - rx_base, ex_n);
    for (int i = 0; i < ex_n; i++)
      chk($sformatf("%s_byte%0d", nm, i), int'(rx[rx_base + i]), int'(ex[i]));
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  typedef struct packed {
    logic [3:0][2:0]      cnt;
    logic [3:0][3:0][7:0] dat;
    logic [7:0][7:0]      exp;
    logic [3:0]           exp_len;
    logic [1:0]           last_ch;
  } vec_t;

  vec_t vt [5];

  initial begin
    int a0;
    int t;
    logic stable;

    for (int i = 0; i < 5; i++) vt[i] = '0;
    vt[0].cnt[2] = 3'd2; vt[0].dat[2] = {16'h0, 8'h42, 8'h41};
    vt[0].exp = {40'h0, 8'h42, 8'h41, 8'hF2}; vt[0].exp_len = 4'd3; vt[0].last_ch = 2'd2;
    vt[1].cnt[0] = 3'd3; vt[1].dat[0] = {8'h0, 8'hA2, 8'hA1, 8'hA0};
    vt[1].cnt[1] = 3'd3; vt[1].dat[1] = {8'h0, 8'hB2, 8'hB1, 8'hB0};
    vt[1].exp = {8'hB2, 8'hB1, 8'hB0, 8'hF1, 8'hA2, 8'hA1, 8'hA0, 8'hF0};
    vt[1].exp_len = 4'd8; vt[1].last_ch = 2'd1;
    vt[2].cnt[1] = 3'd1; vt[2].dat[1] = 32'h11;
    vt[2].exp = 64'h11; vt[2].exp_len = 4'd1; vt[2].last_ch = 2'd1;
    vt[3].cnt[3] = 3'd1; vt[3].dat[3] = 32'h33; vt[3].cnt[0] = 3'd1; vt[3].dat[0] = 32'h05;
    vt[3].exp = {32'h0, 8'h05, 8'hF0, 8'h33, 8'hF3}; vt[3].exp_len = 4'd4; vt[3].last_ch = 2'd0;
    vt[4].cnt[0] = 3'd1; vt[4].dat[0] = 32'h06;
    vt[4].exp = 64'h06; vt[4].exp_len = 4'd1; vt[4].last_ch = 2'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_advance", int'(fifo_advance), 0);
    chk("rst_grant", int'(grant_ch), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      rx_base = rx_n;
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < int'(vt[v].cnt[k]); j++) push(k, vt[v].dat[k][j]);
      ex_n = int'(vt[v].exp_len);
      for (int i = 0; i < ex_n; i++) ex[i] = vt[v].exp[i];
      check_stream($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_grant", v), int'(grant_ch), int'(vt[v].last_ch));
    end

    // Burst limit: ch0 yields to ch3 after 16 bytes, then resumes with a fresh tag.
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    rx_base = rx_n;
    for (int i = 0; i < 20; i++) push(0, 8'(8'h20 + i));
    push(3, 8'h77);
    ex_n = 0;
    ex[ex_n++] = 8'hF0;
    for (int i = 0; i < 16; i++) ex[ex_n++] = 8'(8'h20 + i);
    ex[ex_n++] = 8'hF3; ex[ex_n++] = 8'h77; ex[ex_n++] = 8'hF0;
    for (int i = 16; i < 20; i++) ex[ex_n++] = 8'(8'h20 + i);
    check_stream("burst");

    // Backpressure: tag and data held while tx_ready is low, one advance after.
    rx_base = rx_n;
    tx_ready = 1'b0;
    push(1, 8'h5A);
    t = 0;
    while (!tx_valid && t < 40) begin @(negedge clk); t++; end
    chk("bp_tag_data", int'(tx_data), 8'hF1);
    stable = 1'b1;
    repeat (10) begin @(negedge clk); if (!tx_valid || tx_data != 8'hF1) stable = 1'b0; end
    chk("bp_tag_stable", int'(stable), 1);
    tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
    t = 0;
    while (!tx_valid && t < 40) begin @(negedge clk); t++; end
    chk("bp_data", int'(tx_data), 8'h5A);
    a0 = adv_cnt[1];
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!tx_valid || tx_data != 8'h5A || fifo_advance != 4'h0) stable = 1'b0;
    end
    chk("bp_data_stable", int'(stable), 1);
    tx_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("bp_advances", adv_cnt[1] - a0, 1);
    ex_n = 2; ex[0] = 8'hF1; ex[1] = 8'h5A;
    check_stream("bp");

    // Reset while a data byte waits in SEND: head byte must survive.
    tx_ready = 1'b0;
    push(2, 8'h61); push(2, 8'h62); push(2, 8'h63); push(2, 8'h64); push(2, 8'h65);
    t = 0;
    while (!tx_valid && t < 40) begin @(negedge clk); t++; end
    chk("rst_mid_tag", int'(tx_data), 8'hF2);
    tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
    t = 0;
    while (!tx_valid && t < 40) begin @(negedge clk); t++; end
    chk("rst_mid_head", int'(tx_data), 8'h61);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", int'(tx_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    rst = 1'b0;
    rx_base = rx_n;
    a0 = adv_cnt[2];
    tx_ready = 1'b1;
    ex_n = 6; ex[0] = 8'hF2;
    for (int i = 0; i < 5; i++) ex[i + 1] = 8'(8'h61 + i);
    check_stream("rst_mid");
    chk("rst_mid_advances", adv_cnt[2] - a0, 5);

    // Write lands in the same cycle the last byte is advanced.
    rx_base = rx_n;
    a0 = adv_cnt[3];
    push(3, 8'h71);
    t = 0;
    while (!fifo_advance[3] && t < 60) begin @(negedge clk); t++; end
    chk("late_write_adv_seen", int'(fifo_advance[3]), 1);
    push(3, 8'h72);
    ex_n = 3; ex[0] = 8'hF3; ex[1] = 8'h71; ex[2] = 8'h72;
    check_stream("late_write");
    chk("late_write_advances", adv_cnt[3] - a0, 2);

    chk("protocol_violations", prot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
